// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter fed by single-cycle CPU stores.
// Bytes queue in a circular FIFO; writes arriving while it is full are dropped and flagged.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       uart,
    output logic       busy,
    output logic       full,
    output logic       overflow
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [BAUD_W-1:0] baud_r, baud_s;
    logic [2:0]        bit_idx_r, bit_idx_s;
    logic [7:0]        shift_r, shift_s;
    logic              uart_r, uart_s;
    logic [7:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;
    logic              push_s, pop_s, baud_end_s;

    // Flags derive from the count registered at the start of the cycle, so a
    // write in a full cycle is dropped even when a pop happens alongside it.
    assign full       = (count_r == CNT_W'(FIFO_DEPTH));
    assign busy       = (state_r != IDLE) || (count_r != {CNT_W{1'b0}});
    assign uart       = uart_r;
    assign overflow   = overflow_r;
    assign push_s     = wr_en && !full;
    assign baud_end_s = (baud_r == BAUD_LAST);

    // FIFO storage array; contents need no reset because the pointers qualify them.
    always_ff @(posedge clk) begin
        if (push_s && rst) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // FIFO pointers, occupancy count and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (wr_en && full) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Transmit FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            baud_r    <= {BAUD_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            uart_r    <= 1'b1;
        end else begin
            state_r   <= state_s;
            baud_r    <= baud_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            uart_r    <= uart_s;
        end
    end

    // Next-state logic; the shift register moves right so shift_r[0] is the bit on the line.
    always_comb begin
        state_s   = state_r;
        baud_s    = baud_r + BAUD_W'(1);
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        uart_s    = uart_r;
        pop_s     = 1'b0;
        case (state_r)
            IDLE: begin
                baud_s = {BAUD_W{1'b0}};
                if (count_r != {CNT_W{1'b0}}) begin
                    shift_s = mem_r[rd_ptr_r];
                    pop_s   = 1'b1;
                    uart_s  = 1'b0;
                    state_s = START;
                end else begin
                    uart_s  = 1'b1;
                end
            end
            START: begin
                if (baud_end_s) begin
                    baud_s    = {BAUD_W{1'b0}};
                    uart_s    = shift_r[0];
                    bit_idx_s = 3'd0;
                    state_s   = DATA;
                end else begin
                    uart_s    = 1'b0;
                end
            end
            DATA: begin
                if (baud_end_s) begin
                    baud_s = {BAUD_W{1'b0}};
                    if (bit_idx_r == 3'd7) begin
                        uart_s  = 1'b1;
                        state_s = STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                        shift_s   = {1'b0, shift_r[7:1]};
                        uart_s    = shift_r[1];
                    end
                end else begin
                    uart_s = shift_r[0];
                end
            end
            STOP: begin
                uart_s = 1'b1;
                if (baud_end_s) begin
                    baud_s  = {BAUD_W{1'b0}};
                    state_s = IDLE;
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                baud_s  = {BAUD_W{1'b0}};
                uart_s  = 1'b1;
                state_s = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle comparison against a frame-timing
// reference model, a serial decoder recovering bytes, vector table and directed sequences.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       uart, busy, full, overflow;

    int checks = 0;
    int errors = 0;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .uart(uart), .busy(busy), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a byte queue, the start edge of the frame on the line,
    // and the earliest edge at which the transmitter may take the next byte.
    int         edge_n     = 0;
    logic [7:0] mq[$];
    logic [7:0] acc_q[$];
    int         next_free  = 0;
    bit         cur_active = 1'b0;
    int         cur_start  = 0;
    logic [7:0] cur_byte   = 8'h00;
    bit         m_ovf      = 1'b0;
    bit         was_full;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            next_free  = 0;
            cur_active = 1'b0;
            m_ovf      = 1'b0;
        end else begin
            edge_n++;
            was_full = (mq.size() == DEPTH);
            if (mq.size() > 0 && edge_n >= next_free) begin
                cur_byte   = mq.pop_front();
                cur_start  = edge_n;
                cur_active = 1'b1;
                next_free  = edge_n + FRAME + 1;
            end
            if (wr_en) begin
                if (was_full) begin
                    m_ovf = 1'b1;
                end else begin
                    mq.push_back(wr_data);
                    acc_q.push_back(wr_data);
                end
            end
        end
    end

    function automatic logic exp_line(input int c);
        int pos;
        if (!cur_active || c < cur_start || c >= cur_start + FRAME) return 1'b1;
        pos = (c - cur_start) / CPB;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return cur_byte[pos-1];
    endfunction

    function automatic logic exp_busy();
        return (mq.size() > 0) || (cur_active && edge_n < cur_start + FRAME);
    endfunction

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        chk("line_state", {28'd0, uart, busy, full, overflow},
            {28'd0, exp_line(edge_n), exp_busy(), (mq.size() == DEPTH), m_ovf});
    end

    // Serial decoder: LSB first, sampling one cycle into each bit period.
    logic [7:0] rx_q[$];
    int         rx_t[$];
    bit         dec_in    = 1'b0;
    int         dec_start = 0;
    int         rel;
    logic [7:0] dec_byte  = 8'h00;
    logic       prev_uart = 1'b1;

    always @(negedge clk) begin
        if (!rst) begin
            dec_in    = 1'b0;
            prev_uart = 1'b1;
        end else begin
            if (!dec_in) begin
                if (prev_uart && !uart) begin
                    dec_in    = 1'b1;
                    dec_start = edge_n;
                end
            end else begin
                rel = edge_n - dec_start;
                if (rel > 1 && rel < 9 * CPB && (rel - 1) % CPB == 0) begin
                    dec_byte = {uart, dec_byte[7:1]};
                end
                if (rel == 9 * CPB + 1) begin
                    chk("stop_bit", {31'd0, uart}, 32'd1);
                    rx_q.push_back(dec_byte);
                    rx_t.push_back(dec_start);
                    dec_in = 1'b0;
                end
            end
            prev_uart = uart;
        end
    end

    typedef struct {
        int         rel;
        logic       wr_en;
        logic [7:0] data;
        logic       exp_uart;
        logic       exp_busy;
        logic       exp_full;
    } vec_t;
    vec_t tbl[17];

    task automatic do_write(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain"}, {31'd0, busy}, 32'd0);
    endtask

    int         base;
    int         t0;
    int         pct;
    logic [7:0] d;
    logic [7:0] sent[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{10, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{11, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{14, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{15, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{18, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{19, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{23, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{27, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{31, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{35, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{39, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{43, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{46, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{47, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{50, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[15] = '{51, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{60, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {28'd0, uart, busy, full, overflow}, 32'h8);
        rst = 1'b1;

        // Idle line after reset.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("idle_line", {29'd0, uart, busy, full}, 32'h4);
        end

        // Single byte 0x55, vector table relative to base edge.
        base = edge_n;
        for (int i = 0; i < 17; i++) begin
            while (edge_n < base + tbl[i].rel - 1) @(negedge clk);
            wr_en   = tbl[i].wr_en;
            wr_data = tbl[i].data;
            @(negedge clk);
            wr_en   = 1'b0;
            chk($sformatf("vec%0d_rel%0d", i, tbl[i].rel), {29'd0, uart, busy, full},
                {29'd0, tbl[i].exp_uart, tbl[i].exp_busy, tbl[i].exp_full});
        end

        // Back-to-back writes.
        rx_q.delete(); rx_t.delete();
        do_write(8'hA3);
        do_write(8'h0F);
        wait_idle("b2b", 300);
        chk("b2b_frames", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            chk("b2b_byte0", {24'd0, rx_q[0]}, 32'hA3);
            chk("b2b_byte1", {24'd0, rx_q[1]}, 32'h0F);
            chk("b2b_gap", 32'(rx_t[1] - rx_t[0]), 32'd41);
        end

        // Pointer wrap: 5 groups of 8, each after busy falls.
        rx_q.delete(); sent.delete();
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 8; i++) begin
                d = 8'($urandom);
                sent.push_back(d);
                do_write(d);
            end
            wait_idle("wrap", 1000);
        end
        chk("wrap_count", 32'(rx_q.size()), 32'd40);
        for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
            chk($sformatf("wrap_byte%0d", i), {24'd0, rx_q[i]}, {24'd0, sent[i]});
        end
        chk("wrap_no_overflow", {31'd0, overflow}, 32'd0);

        // Overflow: 18 consecutive writes.
        rx_q.delete();
        for (int i = 0; i < 18; i++) begin
            do_write(8'(i));
            if (i == 16) begin
                chk("ovf_full_after17", {31'd0, full}, 32'd1);
                chk("ovf_clear_after17", {31'd0, overflow}, 32'd0);
            end
        end
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        wait_idle("ovf", 1000);
        chk("ovf_frames", 32'(rx_q.size()), 32'd17);
        for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
            chk($sformatf("ovf_byte%0d", i), {24'd0, rx_q[i]}, i);
        end
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Reset during data bit 3 with 3 bytes queued behind the frame.
        rx_q.delete();
        do_write(8'hC6);
        t0 = edge_n;
        do_write(8'h11);
        do_write(8'h22);
        do_write(8'h33);
        while (edge_n < t0 + 1 + 4 * CPB + 1) @(negedge clk);
        chk("pre_reset_bit3", {31'd0, uart}, 32'd0);
        #2 rst = 1'b0;
        #1 chk("async_reset", {28'd0, uart, busy, full, overflow}, 32'h8);
        repeat (3) @(negedge clk);
        chk("held_reset", {28'd0, uart, busy, full, overflow}, 32'h8);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        chk("post_reset_silent", 32'(rx_q.size()), 32'd0);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);
        do_write(8'h3C);
        wait_idle("post_reset", 200);
        chk("post_reset_frames", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() == 1) begin
            chk("post_reset_byte", {24'd0, rx_q[0]}, 32'h3C);
        end

        // Randomised traffic: sparse, bursty (overflowing), then sparse again.
        rx_q.delete(); acc_q.delete();
        for (int i = 0; i < 2500; i++) begin
            pct     = (i < 1200) ? 8 : ((i < 1700) ? 70 : 3);
            wr_en   = ($urandom_range(0, 99) < pct);
            wr_data = 8'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0;
        wait_idle("rand", 3000);
        chk("rand_count", 32'(rx_q.size()), 32'(acc_q.size()));
        for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++) begin
            chk($sformatf("rand_byte%0d", i), {24'd0, rx_q[i]}, {24'd0, acc_q[i]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered UART transmitter on the CPU's `uart` output. It accepts one byte per cycle from the store path when the CPU writes the UART address. It queues the bytes in a small FIFO and serialises them as 8N1 frames, LSB first. The single-cycle CPU cannot stall, so the FIFO absorbs bursts of stores. Writes that arrive while the FIFO is full are dropped and flagged.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200 baud). Must be ≥ 2.
- `FIFO_DEPTH`, default 16: FIFO entries. Must be a power of two, ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  store strobe; high for exactly the cycles in which the CPU stores to the UART address.
- `wr_data`  in  8  byte to transmit; this is the store data bits [7:0].
- `uart`  out  1  serial TX line; idle level is 1; registered output.
- `busy`  out  1  high when the FSM is not in IDLE or the FIFO is not empty.
- `full`  out  1  high when the FIFO count equals FIFO_DEPTH.
- `overflow`  out  1  sticky flag: set when a write is dropped, cleared only by reset.

## Operation
- **FIFO**
  - Circular buffer with read and write pointers of log2(FIFO_DEPTH) bits; both wrap modulo FIFO_DEPTH.
  - Count is log2(FIFO_DEPTH)+1 bits wide.
- **Push:** on `wr_en && !full`, store `wr_data` at the write pointer and advance the pointer.
- **Full-write rule:** `full` is taken from the registered count at the start of the cycle. A write in a full cycle is dropped, even if a pop happens in the same cycle, and `overflow` is set to 1.
- **Pop:** only the FSM in IDLE pops. A push and a pop in the same cycle leave the count unchanged.
- **FSM states:** IDLE, START, DATA, STOP.
  - A baud counter counts 0..CLKS_PER_BIT-1. Each bit period ends when the counter reaches CLKS_PER_BIT-1; the counter resets to 0 on every state change.
  - IDLE: `uart`=1. If the FIFO is not empty, load the head byte into the shift register, pop it, drive `uart`=0 and go to START. Otherwise stay in IDLE.
  - START: `uart`=0 for one bit period, then drive `uart`=shift[0], set bit index to 0 and go to DATA.
  - DATA: hold the bit for one bit period. At the end of the period, if bit index < 7, increment the index and drive the next bit (LSB first). If bit index = 7, drive `uart`=1 and go to STOP.
  - STOP: `uart`=1 for one bit period, then go to IDLE.
- **Frame spacing:** a frame is 10×CLKS_PER_BIT cycles. There is always exactly one additional IDLE cycle (line = 1) between back-to-back frames.
- **Reset (`rst`=0, at any time, including mid-frame):**
  - `uart`=1, `busy`=0, `full`=0, `overflow`=0.
  - FSM goes to IDLE; pointers, count, baud counter and bit index are cleared.
  - Any frame in flight is aborted and all queued bytes are discarded.
- **While in reset:** `wr_en` is ignored.

## Timing
- **Write to start bit:** with the FIFO empty and the FSM in IDLE, `wr_en` sampled at edge N gives `uart`=0 from edge N+1.
- **Status flags:** `full` and `busy` are combinational from registered state. They reflect the edge-N push from edge N onward.
- **Start-bit timing:** the start bit's falling edge occurs exactly 1 cycle after the push edge.
- **Bit boundaries:** bit k (0..7) begins (k+1)×CLKS_PER_BIT cycles after the start-bit edge. The stop bit begins 9×CLKS_PER_BIT cycles after it.
- **Next pop:** occurs at the edge that ends the single IDLE cycle following STOP.
- **Reset release:** reset deassertion is synchronous to `clk`. The first push is accepted at the first rising edge with `rst`=1.

## Test plan
- **Single byte:** CLKS_PER_BIT=4; one write of 0x55 at edge 10.
  - Required: `uart` is 0 for edges 11–14, then the data bits 1,0,1,0,1,0,1,0 for 4 cycles each over edges 15–46, then 1 from edge 47 onward.
  - `busy` falls at edge 51.
- **Back-to-back:** CLKS_PER_BIT=4; writes of 0xA3 and 0x0F on consecutive cycles.
  - Required: two correct frames separated by exactly 1 extra mark cycle; the gap between start-bit edges is 41 cycles.
- **Overflow:** FIFO_DEPTH=16; 18 consecutive writes of 0x00..0x11.
  - Required: `full`=1 after the 17th write; the 18th write (0x11) is dropped and `overflow`=1.
  - Exactly 17 frames are output, carrying 0x00..0x10 in order; then `busy`=0 and `overflow` remains 1.
- **Pointer wrap:** 40 writes in groups of 8, each group issued only after `busy` falls.
  - Required: all 40 bytes are output in order with none lost or duplicated; `overflow` stays 0.
- **Reset mid-frame:** assert `rst`=0 during DATA bit 3 with 3 bytes queued.
  - Required: `uart`=1 immediately, without waiting for a clock edge; `busy`=0.
  - After release, no frame is output until a new write arrives.
- **Idle line:** no writes for 1000 cycles after reset.
  - Required: `uart`=1, `busy`=0 and `full`=0 throughout.
